// File: rtl/jtag_pkg.sv
// Shared types and TMS sequence constants for the JTAG shift driver.
// Sequences are stored LSB-first: bit 0 is the first TMS value driven.
package jtag_pkg;

    localparam int unsigned MAX_LEN = 32;

    typedef enum logic [1:0] {
        CmdTlrReset   = 2'd0,
        CmdIrScan     = 2'd1,
        CmdDrScan     = 2'd2,
        CmdIdleCycles = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        StInit,
        StWait,
        StHead,
        StShift,
        StTail,
        StRun
    } state_e;

    localparam logic [5:0] IR_HDR_TMS = 6'b00_0011;
    localparam logic [5:0] IR_HDR_LEN = 6'd4;
    localparam logic [5:0] DR_HDR_TMS = 6'b00_0001;
    localparam logic [5:0] DR_HDR_LEN = 6'd3;
    localparam logic [5:0] TLR_TMS    = 6'b01_1111;
    localparam logic [5:0] TLR_LEN    = 6'd6;
    localparam logic [1:0] TAIL_TMS   = 2'b01;
    localparam logic [5:0] TAIL_LEN   = 6'd2;

    // TLR_RESET is driven as a header-only sequence.
    function automatic logic [5:0] hdr_len(cmd_e t);
        case (t)
            CmdIrScan: return IR_HDR_LEN;
            CmdDrScan: return DR_HDR_LEN;
            default:   return TLR_LEN;
        endcase
    endfunction

    function automatic logic [5:0] hdr_tms(cmd_e t);
        case (t)
            CmdIrScan: return IR_HDR_TMS;
            CmdDrScan: return DR_HDR_TMS;
            default:   return TLR_TMS;
        endcase
    endfunction

    function automatic logic [5:0] clamp_len(logic [5:0] len);
        if (len == 6'd0) return 6'd1;
        if (len > 6'(MAX_LEN)) return 6'(MAX_LEN);
        return len;
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// 32-bit payload shifter: presents TDI bits LSB first and captures TDO into
// the bit position of the step being shifted, with a count of shifted bits.
module jtag_shift_reg
    import jtag_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        shift_i,
    input  logic        tdo_i,
    output logic        tdi_o,
    output logic [5:0]  cnt_o,
    output logic [31:0] cap_o
);

    logic [31:0] sr_q, sr_d;
    logic [31:0] cap_q, cap_d;
    logic [5:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = data_i;
            cap_d = '0;
            cnt_d = '0;
        end else if (shift_i) begin
            sr_d               = {1'b0, sr_q[31:1]};
            cap_d[cnt_q[4:0]]  = tdo_i;
            cnt_d              = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            cap_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cap_q <= cap_d;
            cnt_q <= cnt_d;
        end
    end

    // Bit for the following step: the one after the shift if shifting now.
    assign tdi_o = shift_i ? sr_q[1] : sr_q[0];
    assign cnt_o = cnt_q;
    assign cap_o = cap_q;

endmodule

// File: rtl/jtag_shift_driver.sv
// Command-driven JTAG TAP sequencer: TLR reset, IR/DR scans and idle cycles,
// with registered TMS/TDI and a one-cycle completion response.
module jtag_shift_driver
    import jtag_pkg::*;
(
    input  logic        TCK,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [5:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO,
    output logic        rsp_valid,
    output logic [31:0] rsp_data
);

    state_e      state_q, state_d;
    logic [5:0]  step_q, step_d;
    cmd_e        type_q, type_d;
    logic [5:0]  len_q, len_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        accept, done, shift_en, sr_tdi;
    logic [5:0]  sr_cnt, shift_idx_d, hdr_bits;
    logic [31:0] sr_cap;

    assign accept   = cmd_valid && (state_q == StWait);
    assign shift_en = (state_q == StShift);

    jtag_shift_reg u_shift_reg (
        .clk_i  (TCK),
        .rst_i  (Reset),
        .load_i (accept),
        .data_i (cmd_data),
        .shift_i(shift_en),
        .tdo_i  (TDO),
        .tdi_o  (sr_tdi),
        .cnt_o  (sr_cnt),
        .cap_o  (sr_cap)
    );

    // INIT step_q counts walk steps already driven (0 = reset value on TMS).
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        type_d  = type_q;
        len_d   = len_q;
        done    = 1'b0;
        unique case (state_q)
            StInit: begin
                if (step_q == TLR_LEN) begin
                    state_d = StWait;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 6'd1;
                end
            end
            StWait: begin
                if (accept) begin
                    type_d = cmd_e'(cmd_type);
                    step_d = '0;
                    if (cmd_e'(cmd_type) == CmdIdleCycles) begin
                        len_d = cmd_len;
                        if (cmd_len == 6'd0) done = 1'b1;
                        else                 state_d = StRun;
                    end else begin
                        len_d   = clamp_len(cmd_len);
                        state_d = StHead;
                    end
                end
            end
            StHead: begin
                if (step_q == hdr_len(type_q) - 6'd1) begin
                    step_d = '0;
                    if (type_q == CmdTlrReset) begin
                        state_d = StWait;
                        done    = 1'b1;
                    end else begin
                        state_d = StShift;
                    end
                end else begin
                    step_d = step_q + 6'd1;
                end
            end
            StShift: begin
                if (sr_cnt == len_q - 6'd1) begin
                    state_d = StTail;
                    step_d  = '0;
                end
            end
            StTail: begin
                if (step_q == TAIL_LEN - 6'd1) begin
                    state_d = StWait;
                    done    = 1'b1;
                end else begin
                    step_d = step_q + 6'd1;
                end
            end
            StRun: begin
                if (step_q == len_q - 6'd1) begin
                    state_d = StWait;
                    done    = 1'b1;
                end else begin
                    step_d = step_q + 6'd1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Output values for the step entered on the coming edge.
    always_comb begin
        tms_d       = 1'b0;
        tdi_d       = 1'b0;
        hdr_bits    = hdr_tms(type_d);
        shift_idx_d = (state_q == StShift) ? sr_cnt + 6'd1 : 6'd0;
        unique case (state_d)
            StInit:  tms_d = (step_d != TLR_LEN);
            StHead:  tms_d = hdr_bits[step_d[2:0]];
            StShift: begin
                tms_d = (shift_idx_d == len_d - 6'd1);
                tdi_d = sr_tdi;
            end
            StTail:  tms_d = TAIL_TMS[step_d[0]];
            default: tms_d = 1'b0;
        endcase
        rsp_valid_d = done;
        rsp_data_d  = rsp_data_q;
        if (done) begin
            rsp_data_d = (type_d == CmdIrScan || type_d == CmdDrScan) ? sr_cap : '0;
        end
    end

    always_ff @(posedge TCK) begin
        if (Reset) begin
            state_q     <= StInit;
            step_q      <= '0;
            type_q      <= CmdTlrReset;
            len_q       <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            type_q      <= type_d;
            len_q       <= len_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == StWait);
    assign TMS       = tms_q;
    assign TDI       = tdi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule
